// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchronizer, centre sampling, framing-error detection.
// Define UART_RX_PARITY_EN for 8E1 frames with an even-parity bit and parity_err pulse.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 500,
  parameter int unsigned DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 rx_busy
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned IdxW = $clog2(DATA_BITS);
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] CntMid  = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StBreak
`ifdef UART_RX_PARITY_EN
    , StParity
`endif
  } state_e;

  state_e               state_q, state_d;
  logic                 sync1_q, rx_s;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
  logic                 par_q, par_d;
  logic                 perr_q, perr_d;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b1;
      rx_s    <= 1'b1;
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      sync1_q <= rx;
      rx_s    <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
      perr_q  <= perr_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q == CntLast) ? '0 : cnt_q + CntW'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    perr_d  = 1'b0;
`endif
    case (state_q)
      StIdle: begin
        cnt_d = '0;
        idx_d = '0;
        if (!rx_s) state_d = StStart;
      end
      StStart: begin
        // Half a bit in: a high line here means the falling edge was a glitch.
        if (cnt_q == CntMid) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s ? StIdle : StData;
        end
      end
      StData: begin
        if (cnt_q == CntLast) begin
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          idx_d   = idx_q + IdxW'(1);
          if (idx_q == IdxLast) begin
`ifdef UART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (cnt_q == CntLast) begin
          par_d   = rx_s;
          state_d = StStop;
        end
      end
`endif
      StStop: begin
        if (cnt_q == CntLast) begin
          if (!rx_s) begin
            ferr_d  = 1'b1;
            state_d = StBreak;
          end else begin
            state_d = StIdle;
`ifdef UART_RX_PARITY_EN
            if (par_q != ^shift_q) begin
              perr_d = 1'b1;
            end else begin
              valid_d = 1'b1;
              data_d  = shift_q;
            end
`else
            valid_d = 1'b1;
            data_d  = shift_q;
`endif
          end
        end
      end
      StBreak: begin
        cnt_d = '0;
        if (rx_s) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign rx_busy   = (state_q != StIdle);
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus randomized frames
// compared against an event-list model (byte, framing error or parity error per frame).
module tb_uart_rx;

  localparam int CPB = 16;
  localparam int DB  = 8;
`ifdef UART_RX_PARITY_EN
  localparam int FB = DB + 3;
`else
  localparam int FB = DB + 2;
`endif
  localparam int EvFerr = -1;
  localparam int EvPerr = -2;

  logic          clk = 1'b0;
  logic          reset;
  logic          rx;
  logic [DB-1:0] rx_data;
  logic          rx_valid;
  logic          frame_err;
  logic          parity_err;
  logic          rx_busy;

  int  checks = 0;
  int  errors = 0;
  int  ev_q[$];
  time ev_t[$];
  int  overlap = 0;
  int  busy_bad = 0;
  time last_start;

  uart_rx #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (DB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .rx_busy   (rx_busy)
  );

  always #5 clk = ~clk;

  // Records every output pulse as an event for the tests to inspect.
  always @(negedge clk) begin
    if (rx_valid) begin
      ev_q.push_back(int'(rx_data));
      ev_t.push_back($time);
      if (rx_busy) busy_bad = busy_bad + 1;
    end
    if (frame_err) ev_q.push_back(EvFerr);
    if (parity_err) ev_q.push_back(EvPerr);
    if (rx_valid && (frame_err || parity_err)) overlap = overlap + 1;
  end

  task automatic clear_events();
    ev_q.delete();
    ev_t.delete();
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
  endtask

  // Drives one whole frame; leaves rx at the stop-bit level.
  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit par_ok);
    rx = 1'b0;
    last_start = $time;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < DB; i++) begin
      rx = d[i];
      repeat (CPB) @(posedge clk);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^d) ^ ~par_ok;
    repeat (CPB) @(posedge clk);
`endif
    rx = stop_ok;
    repeat (CPB) @(posedge clk);
  endtask

  function automatic int ev_at(input int i);
    return (i < ev_q.size()) ? ev_q[i] : -99;
  endfunction

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data got %0h want 0", rx_data); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid got %0b want 0", rx_valid); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %0b want 0", frame_err); end
    checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL reset_parity_err got %0b want 0", parity_err); end
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL reset_rx_busy got %0b want 0", rx_busy); end
    @(posedge clk);
    reset = 1'b0;
    @(posedge clk);
  endtask

  task automatic test_basic();
    int lat;
    int base;
    clear_events();
    send_frame(8'hA5, 1'b1, 1'b1);
    idle(20);
    @(negedge clk);
    checks++; if (ev_q.size() !== 1) begin errors++; $display("FAIL basic_events got %0d want 1", ev_q.size()); end
    checks++; if (ev_at(0) !== 32'hA5) begin errors++; $display("FAIL basic_event got %0h want a5", ev_at(0)); end
    checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL basic_rx_data got %0h want a5", rx_data); end
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL basic_busy got %0b want 0", rx_busy); end
    base = 2 + CPB / 2 + (FB - 1) * CPB + 1;
    lat = (ev_t.size() > 0) ? int'((ev_t[0] - last_start) / 10) : -1;
    checks++;
    if (lat < base - 1 || lat > base + 1) begin
      errors++; $display("FAIL basic_latency got %0d want %0d+-1", lat, base);
    end
    @(posedge clk);
  endtask

  task automatic test_back_to_back();
    int gap;
    clear_events();
    send_frame(8'h00, 1'b1, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b1);
    send_frame(8'h3C, 1'b1, 1'b1);
    idle(30);
    @(negedge clk);
    checks++; if (ev_q.size() !== 3) begin errors++; $display("FAIL b2b_events got %0d want 3", ev_q.size()); end
    checks++; if (ev_at(0) !== 32'h00) begin errors++; $display("FAIL b2b_byte0 got %0h want 0", ev_at(0)); end
    checks++; if (ev_at(1) !== 32'hFF) begin errors++; $display("FAIL b2b_byte1 got %0h want ff", ev_at(1)); end
    checks++; if (ev_at(2) !== 32'h3C) begin errors++; $display("FAIL b2b_byte2 got %0h want 3c", ev_at(2)); end
    gap = (ev_t.size() > 2) ? int'((ev_t[2] - ev_t[1]) / 10) : -1;
    checks++; if (gap !== FB * CPB) begin errors++; $display("FAIL b2b_spacing got %0d want %0d", gap, FB * CPB); end
    @(posedge clk);
  endtask

  task automatic test_glitch();
    clear_events();
    rx = 1'b0;
    repeat (5) @(posedge clk);
    idle(30);
    @(negedge clk);
    checks++; if (ev_q.size() !== 0) begin errors++; $display("FAIL glitch_events got %0d want 0", ev_q.size()); end
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL glitch_busy got %0b want 0", rx_busy); end
    @(posedge clk);
    send_frame(8'h5A, 1'b1, 1'b1);
    idle(20);
    @(negedge clk);
    checks++; if (ev_q.size() !== 1 || ev_at(0) !== 32'h5A) begin
      errors++; $display("FAIL glitch_next got %0h (n=%0d) want 5a", ev_at(0), ev_q.size());
    end
    @(posedge clk);
  endtask

  task automatic test_framing();
    clear_events();
    send_frame(8'h81, 1'b0, 1'b1);
    repeat (40) @(posedge clk);
    idle(30);
    @(negedge clk);
    checks++; if (ev_q.size() !== 1 || ev_at(0) !== EvFerr) begin
      errors++; $display("FAIL framing_events got %0d (n=%0d) want frame_err only", ev_at(0), ev_q.size());
    end
    checks++; if (rx_data !== 8'h5A) begin errors++; $display("FAIL framing_hold got %0h want 5a", rx_data); end
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL framing_busy got %0b want 0", rx_busy); end
    @(posedge clk);
    send_frame(8'h42, 1'b1, 1'b1);
    idle(20);
    @(negedge clk);
    checks++; if (ev_q.size() !== 2 || ev_at(1) !== 32'h42) begin
      errors++; $display("FAIL framing_next got %0h (n=%0d) want 42", ev_at(1), ev_q.size());
    end
    @(posedge clk);
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    d = 8'hC3;
    clear_events();
    rx = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = d[i];
      repeat (CPB) @(posedge clk);
    end
    rx = d[4];
    repeat (CPB / 2) @(posedge clk);
    reset = 1'b1;
    rx = 1'b1;
    @(posedge clk);
    reset = 1'b0;
    idle(40);
    @(negedge clk);
    checks++; if (ev_q.size() !== 0) begin errors++; $display("FAIL rstmid_events got %0d want 0", ev_q.size()); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL rstmid_rx_data got %0h want 0", rx_data); end
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %0b want 0", rx_busy); end
    @(posedge clk);
    send_frame(8'h11, 1'b1, 1'b1);
    idle(20);
    @(negedge clk);
    checks++; if (ev_q.size() !== 1 || ev_at(0) !== 32'h11) begin
      errors++; $display("FAIL rstmid_next got %0h (n=%0d) want 11", ev_at(0), ev_q.size());
    end
    @(posedge clk);
  endtask

  task automatic test_random();
    int         exp_q[$];
    logic [7:0] last_good;
    logic [7:0] d;
    bit         stop_ok;
    bit         par_ok;
    int         gap;
    last_good = 8'h11;
    clear_events();
    for (int n = 0; n < 30; n++) begin
      d       = 8'($urandom);
      stop_ok = ($urandom_range(0, 4) != 0);
      par_ok  = 1'b1;
`ifdef UART_RX_PARITY_EN
      par_ok  = ($urandom_range(0, 3) != 0);
`endif
      gap = stop_ok ? int'($urandom_range(0, 20)) : int'($urandom_range(4, 20));
      if (!stop_ok) begin
        exp_q.push_back(EvFerr);
      end else if (!par_ok) begin
        exp_q.push_back(EvPerr);
      end else begin
        exp_q.push_back(int'(d));
        last_good = d;
      end
      send_frame(d, stop_ok, par_ok);
      idle(gap);
    end
    idle(40);
    @(negedge clk);
    checks++; if (ev_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL random_count got %0d want %0d", ev_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (ev_at(i) !== exp_q[i]) begin
        errors++; $display("FAIL random_event[%0d] got %0d want %0d", i, ev_at(i), exp_q[i]);
      end
    end
    checks++; if (rx_data !== last_good) begin
      errors++; $display("FAIL random_rx_data got %0h want %0h", rx_data, last_good);
    end
    @(posedge clk);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    clear_events();
    send_frame(8'h07, 1'b1, 1'b1);
    idle(20);
    send_frame(8'h07, 1'b1, 1'b0);
    idle(20);
    @(negedge clk);
    checks++; if (ev_q.size() !== 2) begin errors++; $display("FAIL parity_events got %0d want 2", ev_q.size()); end
    checks++; if (ev_at(0) !== 32'h07) begin errors++; $display("FAIL parity_good got %0d want 7", ev_at(0)); end
    checks++; if (ev_at(1) !== EvPerr) begin errors++; $display("FAIL parity_bad got %0d want -2", ev_at(1)); end
    checks++; if (rx_data !== 8'h07) begin errors++; $display("FAIL parity_hold got %0h want 07", rx_data); end
    @(posedge clk);
  endtask
`endif

  task automatic test_exclusive();
    checks++; if (overlap !== 0) begin errors++; $display("FAIL exclusive_pulses got %0d want 0", overlap); end
    checks++; if (busy_bad !== 0) begin errors++; $display("FAIL busy_at_valid got %0d want 0", busy_bad); end
  endtask

  initial begin
    reset = 1'b1;
    rx    = 1'b1;
    test_reset();
    test_basic();
    test_back_to_back();
    test_glitch();
    test_framing();
    test_reset_mid();
    test_random();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_exclusive();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
